// File: rtl/mips_alu_pkg.sv
// mips_alu_pkg: opcode constants and control type
// shared by the ALU core and its registered top.
package mips_alu_pkg;

  typedef logic [3:0] alu_ctl_t;

  localparam alu_ctl_t ALU_AND = 4'b0000;
  localparam alu_ctl_t ALU_OR  = 4'b0001;
  localparam alu_ctl_t ALU_ADD = 4'b0010;
  localparam alu_ctl_t ALU_SUB = 4'b0110;
  localparam alu_ctl_t ALU_SLT = 4'b0111;
  localparam alu_ctl_t ALU_NOR = 4'b1100;

  function automatic logic is_sub_op(
    input alu_ctl_t ctl
  );
    return (ctl == ALU_SUB) ||
           (ctl == ALU_SLT);
  endfunction

endpackage

// File: rtl/mips_alu_core.sv
// mips_alu_core: combinational MIPS ALU datapath.
// In: a, b, alu_ctl. Out: res (WIDTH bits).
module mips_alu_core
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  alu_ctl_t         alu_ctl,
  output logic [WIDTH-1:0] res
);

  localparam int MSB = WIDTH - 1;

  logic             w_sub;
  logic [WIDTH-1:0] w_bx;
  logic [WIDTH-1:0] w_cin;
  logic [WIDTH-1:0] w_sum;
  logic             w_ovf;
  logic             w_less;
  logic [WIDTH-1:0] w_slt;

  logic w_is_and;
  logic w_is_or;
  logic w_is_add;
  logic w_is_sub;
  logic w_is_slt;
  logic w_is_nor;

  assign w_sub = is_sub_op(alu_ctl);

  // One adder serves ADD, SUB and SLT:
  // subtraction is a + ~b + 1.
  assign w_bx  = w_sub ? ~b : b;
  assign w_cin = {{(WIDTH-1){1'b0}}, w_sub};
  assign w_sum = a + w_bx + w_cin;

  // Signed overflow: operands agree in sign
  // but the sum does not.
  assign w_ovf = (a[MSB] == w_bx[MSB]) &&
                 (w_sum[MSB] != a[MSB]);

  // Sign of a-b is wrong exactly when it
  // overflowed, so XOR restores the truth.
  assign w_less = w_sum[MSB] ^ w_ovf;
  assign w_slt  = {{(WIDTH-1){1'b0}}, w_less};

  assign w_is_and = (alu_ctl == ALU_AND);
  assign w_is_or  = (alu_ctl == ALU_OR);
  assign w_is_add = (alu_ctl == ALU_ADD);
  assign w_is_sub = (alu_ctl == ALU_SUB);
  assign w_is_slt = (alu_ctl == ALU_SLT);
  assign w_is_nor = (alu_ctl == ALU_NOR);

  always_comb begin
    res = '0;
    unique case (1'b1)
      w_is_and: res = a & b;
      w_is_or:  res = a | b;
      w_is_add: res = w_sum;
      w_is_sub: res = w_sum;
      w_is_slt: res = w_slt;
      w_is_nor: res = ~(a | b);
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/mips_alu.sv
// mips_alu: registered MIPS ALU (1-cycle latency).
// In: clk, rst_n, a, b, alu_ctl. Out: alu_out, zero.
module mips_alu
  import mips_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_out,
  output logic             zero
);

  logic [WIDTH-1:0] w_res;
  logic             w_zero;
  logic [WIDTH-1:0] r_out;
  logic             r_zero;

  mips_alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .a      (a),
    .b      (b),
    .alu_ctl(alu_ctl),
    .res    (w_res)
  );

  // Flag derives from the same result that
  // is captured, so it never lags alu_out.
  assign w_zero = ~|w_res;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out  <= '0;
      r_zero <= 1'b1;
    end else begin
      r_out  <= w_res;
      r_zero <= w_zero;
    end
  end

  assign alu_out = r_out;
  assign zero    = r_zero;

endmodule

// File: tb/tb_mips_alu.sv
// tb_mips_alu: directed vectors with literal
// expectations plus a per-cycle reference model.
module tb_mips_alu;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic [3:0]   alu_ctl = '0;
  logic [W-1:0] alu_out;
  logic         zero;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] m_out;
  logic         m_valid = 1'b0;

  mips_alu #(
    .WIDTH(W)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .a      (a),
    .b      (b),
    .alu_ctl(alu_ctl),
    .alu_out(alu_out),
    .zero   (zero)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] model(
    input logic [3:0] c,
    input logic [W-1:0] x,
    input logic [W-1:0] y
  );
    int sx;
    int sy;
    sx = $signed(x);
    sy = $signed(y);
    case (c)
      4'b0000: return x & y;
      4'b0001: return x | y;
      4'b0010: return W'(int'(x) + int'(y));
      4'b0110: return W'(int'(x) - int'(y));
      4'b0111: return (sx < sy) ? W'(1) : W'(0);
      4'b1100: return ~(x | y);
      default: return '0;
    endcase
  endfunction

  always @(posedge clk) begin
    m_out   <= !rst_n ? '0 : model(alu_ctl, a, b);
    m_valid <= 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      checks++;
      if (alu_out !== m_out ||
          zero !== (m_out == '0)) begin
        errors++;
        $display("FAIL model: out=%h z=%b exp=%h z=%b",
                 alu_out, zero, m_out, (m_out == '0));
      end
    end
  end

  task automatic vec(
    input string        nm,
    input logic         r,
    input logic [3:0]   c,
    input logic [W-1:0] x,
    input logic [W-1:0] y,
    input logic [W-1:0] e
  );
    rst_n   = r;
    alu_ctl = c;
    a       = x;
    b       = y;
    @(posedge clk);
    #1;
    checks++;
    if (alu_out !== e || zero !== (e == '0)) begin
      errors++;
      $display("FAIL %s: out=%h z=%b exp=%h z=%b",
               nm, alu_out, zero, e, (e == '0));
    end
  endtask

  initial begin
    vec("rst0", 0, 4'b0010, 8'hFF, 8'hFF, 8'h00);
    vec("rst1", 0, 4'b0010, 8'hFF, 8'hFF, 8'h00);
    vec("post", 1, 4'b0010, 8'hFF, 8'hFF, 8'hFE);
    vec("and",  1, 4'b0000, 8'h01, 8'h03, 8'h01);
    vec("or",   1, 4'b0001, 8'h02, 8'h05, 8'h07);
    vec("nor",  1, 4'b1100, 8'h07, 8'h11, 8'hE8);
    vec("add",  1, 4'b0010, 8'h22, 8'h0B, 8'h2D);
    vec("sub",  1, 4'b0110, 8'h0C, 8'h03, 8'h09);
    vec("addw", 1, 4'b0010, 8'hFF, 8'h01, 8'h00);
    vec("subw", 1, 4'b0110, 8'h00, 8'h01, 8'hFF);
    vec("slt0", 1, 4'b0111, 8'h35, 8'h19, 8'h00);
    vec("slt1", 1, 4'b0111, 8'h19, 8'h35, 8'h01);
    vec("sltv", 1, 4'b0111, 8'h80, 8'h01, 8'h01);
    vec("sltm", 1, 4'b0111, 8'h7F, 8'h80, 8'h00);
    vec("slte", 1, 4'b0111, 8'h42, 8'h42, 8'h00);
    vec("sltn", 1, 4'b0111, 8'hFE, 8'h02, 8'h01);
    vec("ud3",  1, 4'b0011, 8'hF0, 8'h0F, 8'h00);
    vec("udF",  1, 4'b1111, 8'hAA, 8'h55, 8'h00);
    vec("or2",  1, 4'b0001, 8'hA0, 8'h0A, 8'hAA);
    vec("mrst", 0, 4'b0010, 8'h22, 8'h0B, 8'h00);
    vec("rel",  1, 4'b1100, 8'h00, 8'h00, 8'hFF);
    vec("and2", 1, 4'b0000, 8'hF0, 8'h0F, 8'h00);
    vec("sub2", 1, 4'b0110, 8'h80, 8'h01, 8'h7F);
    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
